perf_display_hub: RTL and testbench

- Parametrised successor to the board-level statistics and display path.
- Contains NUM_CH event counters, for example cycles, unconditional branches, conditional branches and bubbles.
- A channel selector picks one counter, or an external data word from the CPU's display port.
- The selected value is shown as 8 hex digits on the board's multiplexed 7-segment display.
- Adds over the fixed-function path: a variable channel count, sticky overflow flags, synchronous clear, display hold, and a parametrised scan rate.

---
 rtl/perf_display_hub_if.sv | 26 ++
 rtl/perf_display_hub.sv | 103 ++++++++++
 tb/tb_perf_display_hub.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_display_hub_if.sv
// Control, source-select and display bus of the statistics/display hub.
// Latency: none, plain wiring bundle.
// Backpressure: none, all signals are level or cycle sampled.
interface perf_display_hub_if #(
    parameter int NUM_CH = 4
);
    logic              cnt_en;
    logic [NUM_CH-1:0] evt;
    logic              clr;
    logic              hold;
    logic [3:0]        sel;
    logic [31:0]       ext_data;
    logic [NUM_CH-1:0] ovf;
    logic [7:0]        SEG;
    logic [7:0]        AN;

    modport master (
        output cnt_en, evt, clr, hold, sel, ext_data,
        input  ovf, SEG, AN
    );

    modport slave (
        input  cnt_en, evt, clr, hold, sel, ext_data,
        output ovf, SEG, AN
    );
endinterface

// File: rtl/perf_display_hub.sv
// Event counters with sticky overflow, source mux and 8-digit multiplexed 7-segment driver.
// Latency: counters->disp_val 1 cycle, disp_val/idx->SEG/AN 1 cycle.
// Backpressure: none; outputs free-run. Optional macro PERF_DISPLAY_LZB_EN blanks leading zeros.
module perf_display_hub #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int SCAN_DIV = 16
) (
    input  logic               clk,
    input  logic               rst,
    perf_display_hub_if.slave  hub
);
    localparam logic [3:0] EXT_SEL = 4'(NUM_CH);

    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic [31:0]         disp_q, disp_d, mux_val;
    logic [SCAN_DIV-1:0] pre_q, pre_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          seg_q, seg_d, an_q, an_d;
    logic [31:0]         disp_shift;
    logic [3:0]          nib;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Counter next state: clear beats increment; wrap from all-ones latches overflow
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (hub.clr) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (hub.cnt_en && hub.evt[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                if (&cnt_q[i]) ovf_d[i] = 1'b1;
            end
        end
    end

    // Source mux over registered counters; unmapped selects show zero
    always_comb begin
        mux_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hub.sel == 4'(i)) mux_val = 32'(cnt_q[i]);
        end
        if (hub.sel == EXT_SEL) mux_val = hub.ext_data;
        disp_d = hub.hold ? disp_q : mux_val;
    end

    // Scan timing: digit advances each time the prescaler wraps
    always_comb begin
        pre_d = pre_q + SCAN_DIV'(1);
        idx_d = (&pre_q) ? idx_q + 3'd1 : idx_q;
    end

    // Segment/anode decode for the current digit
    always_comb begin
        disp_shift = disp_q >> {idx_q, 2'b00};
        nib        = disp_shift[3:0];
        an_d       = ~(8'b1 << idx_q);
        seg_d      = hex_seg(nib);
`ifdef PERF_DISPLAY_LZB_EN
        // Digit 0 always shows, so a zero value still lights one "0"
        if ((idx_q != 3'd0) && (disp_shift == 32'd0)) seg_d = 8'hFF;
`endif
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            ovf_q  <= '0;
            disp_q <= '0;
            pre_q  <= '0;
            idx_q  <= '0;
            seg_q  <= 8'hFF;
            an_q   <= 8'hFF;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            ovf_q  <= ovf_d;
            disp_q <= disp_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign hub.ovf = ovf_q;
    assign hub.SEG = seg_q;
    assign hub.AN  = an_q;
endmodule

// File: tb/tb_perf_display_hub.sv
// Self-checking bench: 32-bit instance against a behavioural model, 4-bit instance for wrap/overflow.
// Latency: checks sample on the falling edge after each rising edge.
// Backpressure: not applicable.
module tb_perf_display_hub;
    localparam int SD = 2;
    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    perf_display_hub_if #(.NUM_CH(4)) ifa ();
    perf_display_hub_if #(.NUM_CH(4)) ifb ();

    perf_display_hub #(.NUM_CH(4), .CNT_W(32), .SCAN_DIV(SD)) u_a (.clk(clk), .rst(rst), .hub(ifa));
    perf_display_hub #(.NUM_CH(4), .CNT_W(4),  .SCAN_DIV(SD)) u_b (.clk(clk), .rst(rst), .hub(ifb));

    // ---------------- behavioural model of instance A ----------------
    longint unsigned m_cnt [4];
    logic [3:0]      m_ovf;
    logic [31:0]     m_disp;
    int unsigned     m_n;
    logic [7:0]      m_seg, m_an;

    function automatic logic [7:0] seg_of(input logic [31:0] v, input int d);
        logic [31:0] upper;
        upper = v >> (4 * d);
`ifdef PERF_DISPLAY_LZB_EN
        if (d != 0 && upper == 0) return 8'hFF;
`endif
        return HEX[upper[3:0]];
    endfunction

    always @(posedge clk) begin
        int d;
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_ovf = '0; m_disp = '0; m_n = 0; m_seg = 8'hFF; m_an = 8'hFF;
        end else begin
            d     = int'((m_n >> SD) % 8);
            m_an  = ~(8'b1 << d);
            m_seg = seg_of(m_disp, d);
            if (!ifa.hold) begin
                if (ifa.sel < 4)       m_disp = 32'(m_cnt[ifa.sel]);
                else if (ifa.sel == 4) m_disp = ifa.ext_data;
                else                   m_disp = 32'd0;
            end
            for (int i = 0; i < 4; i++) begin
                if (ifa.clr) begin
                    m_cnt[i] = 0; m_ovf[i] = 1'b0;
                end else if (ifa.cnt_en && ifa.evt[i]) begin
                    if (m_cnt[i] == 64'hFFFF_FFFF) begin m_cnt[i] = 0; m_ovf[i] = 1'b1; end
                    else m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_n = m_n + 1;
        end
    end

    // Scan the display once and reassemble the shown 32-bit value (blank digits read as 0)
    task automatic read_display(input bit use_b, output logic [31:0] v, output bit ok);
        bit [7:0] seen;
        logic [7:0] an, seg;
        int nib;
        v = '0; ok = 1'b1; seen = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 40 && seen != 8'hFF; c++) begin
            @(negedge clk);
            an  = use_b ? ifb.AN  : ifa.AN;
            seg = use_b ? ifb.SEG : ifa.SEG;
            for (int j = 0; j < 8; j++) begin
                if (an == ~(8'b1 << j)) begin
                    nib = (seg == 8'hFF) ? 0 : -1;
                    for (int k = 0; k < 16; k++) if (HEX[k] == seg) nib = k;
                    if (nib < 0) ok = 1'b0;
                    else v[4*j +: 4] = 4'(nib);
                    seen[j] = 1'b1;
                end
            end
        end
        if (seen != 8'hFF) ok = 1'b0;
    endtask

    task automatic idle_inputs();
        ifa.cnt_en = 0; ifa.evt = '0; ifa.clr = 0; ifa.hold = 0; ifa.sel = 0; ifa.ext_data = '0;
        ifb.cnt_en = 0; ifb.evt = '0; ifb.clr = 0; ifb.hold = 0; ifb.sel = 0; ifb.ext_data = '0;
    endtask

    task automatic test_reset();
        logic [7:0] an_seq [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
        idle_inputs();
        ifa.cnt_en = 1; ifb.cnt_en = 1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ifa.evt = (c % 2 == 0) ? 4'hF : 4'h0;
            ifb.evt = ifa.evt;
            @(negedge clk);
            checks++;
            if (ifa.SEG !== 8'hFF || ifa.AN !== 8'hFF || ifa.ovf !== 4'h0 || ifb.AN !== 8'hFF) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: SEG=%h AN=%h ovf=%b ANb=%h, want FF FF 0000 FF",
                         c, ifa.SEG, ifa.AN, ifa.ovf, ifb.AN);
            end
        end
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            checks++;
            if (ifa.AN !== an_seq[k/4]) begin
                errors++;
                $display("FAIL an_sequence k=%0d: AN=%h want %h", k, ifa.AN, an_seq[k/4]);
            end
        end
    endtask

    task automatic test_count_display();
        logic [7:0] want;
        ifa.sel = 1; ifa.cnt_en = 1; ifa.evt = 4'b0010;
        repeat (5) @(negedge clk);
        ifa.evt = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
`ifdef PERF_DISPLAY_LZB_EN
            want = (ifa.AN == 8'hFE) ? 8'h92 : 8'hFF;
`else
            want = (ifa.AN == 8'hFE) ? 8'h92 : 8'hC0;
`endif
            checks++;
            if (ifa.SEG !== want) begin
                errors++;
                $display("FAIL count_display AN=%h: SEG=%h want %h", ifa.AN, ifa.SEG, want);
            end
        end
    endtask

    task automatic test_enable_ext();
        logic [31:0] v; bit ok;
        ifa.cnt_en = 0;
        for (int c = 0; c < 10; c++) begin
            ifa.evt = (c % 2 == 0) ? 4'b0010 : 4'b0000;
            @(negedge clk);
        end
        ifa.evt = '0;
        read_display(1'b0, v, ok);
        checks++;
        if (!ok || v !== 32'd5) begin errors++; $display("FAIL enable_off: shown=%h ok=%0d want 00000005", v, ok); end
        ifa.sel = 4; ifa.ext_data = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (ifa.AN == 8'h7F) begin
                checks++;
                if (ifa.SEG !== 8'hA1) begin errors++; $display("FAIL ext_digit7: SEG=%h want A1", ifa.SEG); end
            end
            if (ifa.AN == 8'hFE) begin
                checks++;
                if (ifa.SEG !== 8'h8E) begin errors++; $display("FAIL ext_digit0: SEG=%h want 8E", ifa.SEG); end
            end
        end
        read_display(1'b0, v, ok);
        checks++;
        if (!ok || v !== 32'hDEADBEEF) begin errors++; $display("FAIL ext_value: shown=%h ok=%0d want DEADBEEF", v, ok); end
        ifa.sel = 5;
        read_display(1'b0, v, ok);
        checks++;
        if (!ok || v !== 32'd0) begin errors++; $display("FAIL sel_above_ext: shown=%h ok=%0d want 0", v, ok); end
    endtask

    task automatic test_wrap_overflow();
        logic [31:0] v; bit ok;
        ifb.sel = 0; ifb.cnt_en = 1; ifb.evt = 4'b0001;
        repeat (16) @(negedge clk);
        ifb.evt = '0;
        read_display(1'b1, v, ok);
        checks++;
        if (!ok || v !== 32'd0 || ifb.ovf !== 4'b0001) begin
            errors++; $display("FAIL wrap16: shown=%h ovf=%b want 0 0001", v, ifb.ovf);
        end
        ifb.evt = 4'b0001; @(negedge clk); ifb.evt = '0;
        read_display(1'b1, v, ok);
        checks++;
        if (!ok || v !== 32'd1 || ifb.ovf !== 4'b0001) begin
            errors++; $display("FAIL wrap17: shown=%h ovf=%b want 1 0001", v, ifb.ovf);
        end
        ifb.clr = 1; @(negedge clk); ifb.clr = 0;
        read_display(1'b1, v, ok);
        checks++;
        if (!ok || v !== 32'd0 || ifb.ovf !== 4'b0000) begin
            errors++; $display("FAIL wrap_clear: shown=%h ovf=%b want 0 0000", v, ifb.ovf);
        end
    endtask

    task automatic test_clr_vs_evt();
        logic [31:0] v; bit ok;
        ifa.sel = 2; ifa.cnt_en = 1; ifa.evt = 4'b0100;
        repeat (9) @(negedge clk);
        ifa.evt = '0;
        read_display(1'b0, v, ok);
        checks++;
        if (!ok || v !== 32'd9) begin errors++; $display("FAIL preclear_count: shown=%h want 9", v); end
        ifa.clr = 1; ifa.evt = 4'b0100;
        @(negedge clk);
        ifa.clr = 0; ifa.evt = '0;
        read_display(1'b0, v, ok);
        checks++;
        if (!ok || v !== 32'd0) begin errors++; $display("FAIL clr_beats_evt: shown=%h want 0", v); end
    endtask

    task automatic test_hold();
        logic [31:0] v; bit ok;
        ifa.sel = 3; ifa.cnt_en = 1; ifa.evt = 4'b1000;
        repeat (3) @(negedge clk);
        ifa.evt = '0;
        repeat (2) @(negedge clk);
        ifa.hold = 1;
        ifa.evt = 4'b1000;
        repeat (4) @(negedge clk);
        ifa.evt = '0; ifa.sel = 1;
        read_display(1'b0, v, ok);
        checks++;
        if (!ok || v !== 32'd3) begin errors++; $display("FAIL hold_frozen: shown=%h want 00000003", v); end
        ifa.hold = 0; ifa.sel = 3;
        read_display(1'b0, v, ok);
        checks++;
        if (!ok || v !== 32'd7) begin errors++; $display("FAIL hold_release: shown=%h want 00000007", v); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (ifa.SEG !== m_seg || ifa.AN !== m_an || ifa.ovf !== m_ovf) begin
                errors++;
                $display("FAIL random cyc%0d: SEG=%h AN=%h ovf=%b want %h %h %b",
                         c, ifa.SEG, ifa.AN, ifa.ovf, m_seg, m_an, m_ovf);
            end
            ifa.cnt_en   = ($urandom_range(0, 3) != 0);
            ifa.evt      = 4'($urandom);
            ifa.clr      = ($urandom_range(0, 40) == 0);
            ifa.hold     = ($urandom_range(0, 5) == 0);
            ifa.sel      = 4'($urandom_range(0, 6));
            ifa.ext_data = $urandom;
        end
    endtask

    initial begin
        test_reset();
        test_count_display();
        test_enable_ext();
        test_wrap_overflow();
        test_clr_vs_evt();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
